opb_register_bank_ppc2simulink: RTL and testbench

//  Parametrised OPB slave bank of N_REGS software-writable control registers for PPC -> fabric control.

---
 rtl/opb_register_bank_ppc2simulink_pkg.sv | 35 +++
 rtl/opb_slave_ack_fsm.sv | 74 +++++++
 rtl/opb_register_bank_ppc2simulink.sv | 176 +++++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared definitions for the OPB register bank: ack FSM state encoding,
// address slicing constants, the latched bus request and byte-lane mask expansion.
package opb_register_bank_ppc2simulink_pkg;

  // Two-state slave handshake: wait for a hit, then acknowledge for one cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  // Registers are word-spaced: byte offset bits [1:0] are ignored.
  localparam int ADDR_LSB = 2;
  // Word index width covers a 256-byte window (64 words).
  localparam int IDX_W    = 6;

  // Bus request captured in IDLE and held for the ACK cycle.
  // Byte enables and data are stored LSB-numbered: be[3] covers data[31:24].
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             rnw;
    logic [3:0]       be;
    logic [31:0]      data;
  } opb_req_t;

  // Expand per-byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_lane_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int j = 0; j < 4; j++) begin
      mask[8*j +: 8] = {8{be[j]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: address-range decode, IDLE/ACK state machine,
// request capture and read-data gating so Sl_DBus is zero outside the ack cycle.
module opb_slave_ack_fsm
  import opb_register_bank_ppc2simulink_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_9000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_90FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic [0:3]            be,
  input  logic [0:31]           dbus,
  input  logic                  rnw,
  input  logic                  select,
  input  logic [31:0]           rd_data,
  output logic                  ack,
  output opb_req_t              req,
  output logic [0:31]           sl_dbus
);

  ack_state_e              state;
  ack_state_e              next_state;
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic                    hit;
  logic                    unused_offset;

  // Bus bit 0 is the MSB, so a plain assignment yields the numeric address.
  assign addr   = abus;
  assign hit    = select && (addr >= C_OPB_AWIDTH'(C_BASEADDR))
                         && (addr <= C_OPB_AWIDTH'(C_HIGHADDR));
  assign offset = addr - C_OPB_AWIDTH'(C_BASEADDR);

  // Only the word index of the offset matters; the rest is decoded by the range check.
  assign unused_offset = ^{offset[C_OPB_AWIDTH-1:ADDR_LSB+IDX_W], offset[ADDR_LSB-1:0]};

  // State register with synchronous reset taking priority over any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept a hit in IDLE, always return from ACK after one cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      ST_IDLE: if (hit) next_state = ST_ACK;
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture the request on the accepting edge; it is consumed only while in ACK.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are left unreset; they are only observed when state qualifies them.
    if (state == ST_IDLE && hit) begin
      req <= '{idx:  offset[ADDR_LSB +: IDX_W],
               rnw:  rnw,
               be:   be,
               data: dbus};
    end
  end

  assign ack     = (state == ST_ACK);
  assign sl_dbus = (ack && req.rnw) ? rd_data : '0;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank: N_REGS software-writable control registers for PPC -> fabric
// control with byte-enable writes, per-register write strobes and readback.
// Optional shadow/commit double-buffering is built when OPB_REGBANK_SHADOW_EN is defined;
// the commit slot sits at byte offset 4*N_REGS.
module opb_register_bank_ppc2simulink
  import opb_register_bank_ppc2simulink_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_9000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_90FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          N_REGS       = 8,
  parameter int          REG_WIDTH    = 32,
  parameter logic [31:0] RESET_VAL    = 32'h0
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [N_REGS*REG_WIDTH-1:0] user_data_out,
  output logic [N_REGS-1:0]           user_wr_stb,
  output logic                        user_commit
);

  localparam logic [REG_WIDTH-1:0] RST_V      = RESET_VAL[REG_WIDTH-1:0];
  localparam logic [IDX_W-1:0]     COMMIT_IDX = IDX_W'(N_REGS);
  localparam bit                   FAMILY_SET = (C_FAMILY != "");

  logic                 ack;
  opb_req_t             req;
  logic [31:0]          rd_data;
  logic [31:0]          full_mask;
  logic [REG_WIDTH-1:0] wr_mask;
  logic [REG_WIDTH-1:0] wr_data;
  logic [N_REGS-1:0]    wr_sel;
  logic                 commit_hit;
  logic                 unused_ok;

  logic [REG_WIDTH-1:0] active [N_REGS];

  // Sequential-address hint and family string have no effect on this slave.
  assign unused_ok = ^{OPB_seqAddr, FAMILY_SET, commit_hit, req.data[0]};

  opb_slave_ack_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_ack_fsm (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .abus    (OPB_ABus),
    .be      (OPB_BE),
    .dbus    (OPB_DBus),
    .rnw     (OPB_RNW),
    .select  (OPB_select),
    .rd_data (rd_data),
    .ack     (ack),
    .req     (req),
    .sl_dbus (Sl_DBus)
  );

  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign full_mask = byte_lane_mask(req.be);
  assign wr_mask   = full_mask[REG_WIDTH-1:0];
  assign wr_data   = req.data[REG_WIDTH-1:0];

  // One-hot write select for in-range register writes during the ack cycle.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < N_REGS; k++) begin
      wr_sel[k] = ack && !req.rnw && (req.idx == IDX_W'(k));
    end
  end

  // Commit request: write to the slot just past the last register with bit 0 set.
  assign commit_hit = ack && !req.rnw && (req.idx == COMMIT_IDX) && req.data[0];

  // Active registers drive the fabric side directly.
  always_comb begin
    user_data_out = '0;
    for (int k = 0; k < N_REGS; k++) begin
      user_data_out[k*REG_WIDTH +: REG_WIDTH] = active[k];
    end
  end

`ifdef OPB_REGBANK_SHADOW_EN

  logic [REG_WIDTH-1:0] shadow [N_REGS];
  logic                 commit_q;

  // Shadow registers take bus writes byte-by-byte.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < N_REGS; k++) shadow[k] <= RST_V;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (wr_sel[k]) shadow[k] <= (shadow[k] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  // Active registers load all shadows together on a commit.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < N_REGS; k++) active[k] <= RST_V;
    end else if (commit_hit) begin
      for (int k = 0; k < N_REGS; k++) active[k] <= shadow[k];
    end
  end

  // Commit pulse follows the edge that updated the active set.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) commit_q <= 1'b0;
    else         commit_q <= commit_hit;
  end

  assign user_commit = commit_q;
  assign user_wr_stb = '0;

  // Readback returns the shadow copy; the commit slot and beyond read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (req.idx == IDX_W'(k)) rd_data[REG_WIDTH-1:0] = shadow[k];
    end
  end

`else

  logic [N_REGS-1:0] stb_q;

  // Bus writes update the active registers directly, byte-by-byte.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < N_REGS; k++) active[k] <= RST_V;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (wr_sel[k]) active[k] <= (active[k] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  // Write strobe is high in the cycle after the register changed.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) stb_q <= '0;
    else         stb_q <= wr_sel;
  end

  assign user_wr_stb = stb_q;
  assign user_commit = 1'b0;

  // Readback of the active register; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (req.idx == IDX_W'(k)) rd_data[REG_WIDTH-1:0] = active[k];
    end
  end

`endif

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink. Handles both the default
// build and the OPB_REGBANK_SHADOW_EN build. Expected read data is queued at drive time
// and popped when the slave acknowledges.
module tb_opb_register_bank_ppc2simulink;

  localparam int          N    = 8;
  localparam int          W    = 32;
  localparam logic [31:0] RV   = 32'h0000_005A;
  localparam logic [31:0] BASE = 32'h0108_9000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:31]   abus = '0;
  logic [0:3]    be = '0;
  logic [0:31]   dbus = '0;
  logic          rnw = 1'b0;
  logic          select = 1'b0;
  logic          seq_addr = 1'b0;
  logic [0:31]   sl_dbus;
  logic          sl_ack, sl_err, sl_retry, sl_tout;
  logic [N*W-1:0] data_out;
  logic [N-1:0]  wr_stb;
  logic          commit;

  logic [31:0] exp_act [N];
  logic [31:0] exp_shd [N];
  logic [31:0] rd_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (32'h0108_90FF),
    .N_REGS     (N),
    .REG_WIDTH  (W),
    .RESET_VAL  (RV)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (select),
    .OPB_seqAddr   (seq_addr),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_ack),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .user_data_out (data_out),
    .user_wr_stb   (wr_stb),
    .user_commit   (commit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-lane merge written in bus terms: BE[b] covers DBus[8b:8b+7] = reg bits 31-8b downto 24-8b.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [0:3] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) r[31-8*b -: 8] = d[31-8*b -: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      exp_act[k] = RV;
      exp_shd[k] = RV;
    end
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_lane%0d", tag, k), data_out[k*W +: W], exp_act[k]);
    end
  endtask

  // One in-range transfer: drive on a negedge, expect ack at the next negedge,
  // then check idle bus, strobes and fabric outputs one cycle later.
  task automatic xfer(input string tag, input int idx, input bit r, input logic [0:3] en,
                      input logic [31:0] d);
    logic [N-1:0] exp_stb;
    logic         exp_commit;
    logic [31:0]  exp_rd;
    exp_stb    = '0;
    exp_commit = 1'b0;
    @(negedge clk);
    abus   = BASE + 32'(idx * 4);
    rnw    = r;
    be     = en;
    dbus   = d;
    select = 1'b1;
    if (r) begin
`ifdef OPB_REGBANK_SHADOW_EN
      rd_q.push_back(idx < N ? exp_shd[idx] : 32'h0);
`else
      rd_q.push_back(idx < N ? exp_act[idx] : 32'h0);
`endif
    end else if (idx < N) begin
`ifdef OPB_REGBANK_SHADOW_EN
      exp_shd[idx] = merge(exp_shd[idx], d, en);
`else
      exp_act[idx] = merge(exp_act[idx], d, en);
      exp_stb[idx] = 1'b1;
`endif
    end else begin
`ifdef OPB_REGBANK_SHADOW_EN
      if (idx == N && d[0]) begin
        for (int k = 0; k < N; k++) exp_act[k] = exp_shd[k];
        exp_commit = 1'b1;
      end
`endif
    end
    @(negedge clk);
    select = 1'b0;
    check({tag, "_ack"}, sl_ack, 1'b1);
    if (r && rd_q.size() > 0) begin
      exp_rd = rd_q.pop_front();
      if (sl_ack) check({tag, "_rdata"}, sl_dbus, exp_rd);
    end
    @(negedge clk);
    check({tag, "_ack_drop"}, sl_ack, 1'b0);
    check({tag, "_dbus_idle"}, sl_dbus, 32'h0);
    check({tag, "_stb"}, 32'(wr_stb), 32'(exp_stb));
    check({tag, "_commit"}, commit, exp_commit);
    if (!r) check_lanes(tag);
    @(negedge clk);
    check({tag, "_stb_clr"}, 32'(wr_stb), 32'h0);
    check({tag, "_commit_clr"}, commit, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int idx;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_ack", sl_ack, 1'b0);
    check("rst_dbus", sl_dbus, 32'h0);
    check("rst_stb", 32'(wr_stb), 32'h0);
    check("rst_commit", commit, 1'b0);
    check("rst_aux", {sl_err, sl_retry, sl_tout}, 3'b000);
    check_lanes("rst");

    // Full-word write, readback, then partial byte-enable write.
    xfer("wr_full", 2, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    xfer("rd_full", 2, 1'b1, 4'b1111, 32'h0);
    xfer("wr_part", 2, 1'b0, 4'b0101, 32'h1122_3344);
`ifndef OPB_REGBANK_SHADOW_EN
    check("part_val", exp_act[2], 32'hDE22_BE44);
`endif
    xfer("rd_part", 2, 1'b1, 4'b1111, 32'h0);
    xfer("wr_r7", 7, 1'b0, 4'b1000, 32'hA5A5_A5A5);
    xfer("rd_r7", 7, 1'b1, 4'b1111, 32'h0);

    // Out-of-range index inside the window: acked, reads zero, no effect.
    xfer("rd_oor", 60, 1'b1, 4'b1111, 32'h0);
    xfer("wr_oor", 60, 1'b0, 4'b1111, 32'hFFFF_FFFF);

    // Miss above the window: select held for 20 cycles, never acked.
    @(negedge clk);
    abus = 32'h0108_9100; rnw = 1'b0; be = 4'b1111; dbus = 32'hFFFF_FFFF; select = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sl_ack) acks++;
    end
    select = 1'b0;
    check("miss_acks", 32'(acks), 32'h0);
    @(negedge clk);
    check_lanes("miss");

    // Back-to-back: select held on a read gives an ack every other cycle.
    @(negedge clk);
    abus = BASE + 32'd8; rnw = 1'b1; be = 4'b1111; select = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef OPB_REGBANK_SHADOW_EN
      if (i % 2 == 0) rd_q.push_back(exp_shd[2]);
`else
      if (i % 2 == 0) rd_q.push_back(exp_act[2]);
`endif
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), sl_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (sl_ack && rd_q.size() > 0) begin
        acks++;
        check($sformatf("b2b_rdata%0d", i), sl_dbus, rd_q.pop_front());
      end
    end
    select = 1'b0;
    check("b2b_count", 32'(acks), 32'd3);
    rd_q.delete();

    // Reset asserted during the ack cycle of a write: write dropped, bank reset.
    @(negedge clk);
    abus = BASE + 32'd12; rnw = 1'b0; be = 4'b1111; dbus = 32'h1234_5678; select = 1'b1;
    @(negedge clk);
    select = 1'b0;
    check("rsta_ack", sl_ack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rsta_ack_drop", sl_ack, 1'b0);
    check("rsta_stb", 32'(wr_stb), 32'h0);
    check_lanes("rsta");
    @(negedge clk);
    check("rsta_stb2", 32'(wr_stb), 32'h0);
    xfer("rsta_rd", 3, 1'b1, 4'b1111, 32'h0);
    xfer("rsta_wr", 3, 1'b0, 4'b1111, 32'h0BAD_F00D);

`ifdef OPB_REGBANK_SHADOW_EN
    // Shadow write is invisible to the fabric until committed.
    xfer("shd_wr", 0, 1'b0, 4'b1111, 32'h0000_0007);
    check("shd_active", data_out[0 +: W], RV);
    xfer("shd_rd", 0, 1'b1, 4'b1111, 32'h0);
    xfer("commit_rd", N, 1'b1, 4'b1111, 32'h0);
    xfer("commit_wr", N, 1'b0, 4'b1111, 32'h0000_0001);
    check("commit_r0", data_out[0 +: W], 32'h0000_0007);
`else
    // Commit slot is just another out-of-range index in this build.
    xfer("cslot_wr", N, 1'b0, 4'b1111, 32'h0000_0001);
    xfer("cslot_rd", N, 1'b1, 4'b1111, 32'h0);
`endif

    // Random traffic across all registers and the commit slot.
    for (int i = 0; i < 24; i++) begin
      idx = int'($urandom_range(0, N));
      xfer($sformatf("rnd%0d", i), idx, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
